// File: rtl/mic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic_pkg                                                          |
// | Shared types and sizing helpers for the PDM microphone front-end |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mic_pkg;

   localparam int CIC_ORDER = 3;

   typedef logic signed [1:0] pdm_s_t;

   // Hogenauer growth: 2-bit +/-1 input plus N*log2(R)
   function automatic int cic_out_w(input int r);
      return 2 + CIC_ORDER * $clog2(r);
   endfunction

   function automatic pdm_s_t pdm_map(input logic b);
      return b ? 2'sb01 : 2'sb11;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cic3_decim.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic3_decim                                                       |
// | 3rd-order CIC decimator for one PDM channel, modulo arithmetic   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module cic3_decim
   import mic_pkg::*;
#(
   parameter int OUT_W = 17
) (
   input  logic             std_clk,
   input  logic             s_n_rst,
   input  pdm_s_t           pdm_in,
   input  logic             dec_stb,
   output logic [OUT_W-1:0] pcm_out
);

   logic [OUT_W-1:0] r_integ    [CIC_ORDER];
   logic [OUT_W-1:0] w_integ_in [CIC_ORDER];
   logic [OUT_W-1:0] r_dly      [CIC_ORDER];
   logic [OUT_W-1:0] w_comb_in  [CIC_ORDER];
   logic [OUT_W-1:0] w_acc;
   logic [OUT_W-1:0] w_comb_out;
   logic [OUT_W-1:0] r_latch;
   logic [OUT_W-1:0] r_comb_out;
   logic             r_comb_en;

   always_comb begin
      w_integ_in[0] = {{(OUT_W-2){pdm_in[1]}}, pdm_in};
      for (int i = 1; i < CIC_ORDER; i++) begin
         w_integ_in[i] = r_integ[i-1];
      end
   end

   // Whole comb cascade settles combinationally within the update cycle
   always_comb begin
      w_acc = r_latch;
      for (int i = 0; i < CIC_ORDER; i++) begin
         w_comb_in[i] = w_acc;
         w_acc        = w_acc - r_dly[i];
      end
      w_comb_out = w_acc;
   end

   always_ff @(posedge std_clk or posedge s_n_rst) begin
      if (s_n_rst) begin
         for (int i = 0; i < CIC_ORDER; i++) begin
            r_integ[i] <= '0;
            r_dly[i]   <= '0;
         end
         r_latch    <= '0;
         r_comb_en  <= 1'b0;
         r_comb_out <= '0;
      end else begin
         for (int i = 0; i < CIC_ORDER; i++) begin
            r_integ[i] <= r_integ[i] + w_integ_in[i];
         end
         r_comb_en <= dec_stb;
         if (dec_stb) begin
            r_latch <= r_integ[CIC_ORDER-1];
         end
         if (r_comb_en) begin
            for (int i = 0; i < CIC_ORDER; i++) begin
               r_dly[i] <= w_comb_in[i];
            end
            r_comb_out <= w_comb_out;
         end
      end
   end

   assign pcm_out = r_comb_out;

endmodule
`default_nettype wire

// File: rtl/pdm_stereo_cic.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pdm_stereo_cic                                                   |
// | DDR PDM split, dual CIC decimation and 1-deep valid/ready output |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pdm_stereo_cic
   import mic_pkg::*;
#(
   parameter int DECIM = 32,
   parameter int OUT_W = cic_out_w(DECIM)
) (
   input  logic                    std_clk,
   input  logic                    s_n_rst,
   input  logic                    mic_data,
   input  logic                    pcm_ready,
   input  logic                    ovr_clr,
   output logic signed [OUT_W-1:0] pcm_ch0,
   output logic signed [OUT_W-1:0] pcm_ch1,
   output logic                    pcm_valid,
   output logic                    overrun
);

   localparam int CNT_W = $clog2(DECIM);

   logic             r_ch0_neg;
   logic [CNT_W-1:0] r_frm_cnt;
   logic             w_dec_stb;
   logic             r_stb_q1;
   logic             r_stb_q2;
   pdm_s_t           w_pdm_ch0;
   pdm_s_t           w_pdm_ch1;
   logic [OUT_W-1:0] w_cic_ch0;
   logic [OUT_W-1:0] w_cic_ch1;
   logic [OUT_W-1:0] r_pcm_ch0;
   logic [OUT_W-1:0] r_pcm_ch1;
   logic             r_pcm_valid;
   logic             r_overrun;
   logic             w_xfer;

   // ch0 is stable around the falling edge; ch1 is taken live at the rising edge
   always_ff @(negedge std_clk or posedge s_n_rst) begin
      if (s_n_rst) r_ch0_neg <= 1'b0;
      else         r_ch0_neg <= mic_data;
   end

   assign w_pdm_ch0 = pdm_map(r_ch0_neg);
   assign w_pdm_ch1 = pdm_map(mic_data);
   assign w_dec_stb = &r_frm_cnt;

   always_ff @(posedge std_clk or posedge s_n_rst) begin
      if (s_n_rst) begin
         r_frm_cnt <= '0;
         r_stb_q1  <= 1'b0;
         r_stb_q2  <= 1'b0;
      end else begin
         r_frm_cnt <= r_frm_cnt + 1'b1;
         r_stb_q1  <= w_dec_stb;
         r_stb_q2  <= r_stb_q1;
      end
   end

   cic3_decim #(.OUT_W(OUT_W)) u_cic_ch0 (
      .std_clk (std_clk),
      .s_n_rst (s_n_rst),
      .pdm_in  (w_pdm_ch0),
      .dec_stb (w_dec_stb),
      .pcm_out (w_cic_ch0)
   );

   cic3_decim #(.OUT_W(OUT_W)) u_cic_ch1 (
      .std_clk (std_clk),
      .s_n_rst (s_n_rst),
      .pdm_in  (w_pdm_ch1),
      .dec_stb (w_dec_stb),
      .pcm_out (w_cic_ch1)
   );

   assign w_xfer = r_pcm_valid & pcm_ready;

   // A held sample wins over a new one; set of overrun beats a clear
   always_ff @(posedge std_clk or posedge s_n_rst) begin
      if (s_n_rst) begin
         r_pcm_ch0   <= '0;
         r_pcm_ch1   <= '0;
         r_pcm_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (r_stb_q2) begin
            if (!r_pcm_valid || w_xfer) begin
               r_pcm_ch0   <= w_cic_ch0;
               r_pcm_ch1   <= w_cic_ch1;
               r_pcm_valid <= 1'b1;
            end
         end else if (w_xfer) begin
            r_pcm_valid <= 1'b0;
         end
         if (r_stb_q2 && r_pcm_valid && !pcm_ready) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign pcm_ch0   = r_pcm_ch0;
   assign pcm_ch1   = r_pcm_ch1;
   assign pcm_valid = r_pcm_valid;
   assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pdm_stereo_cic.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pdm_stereo_cic                                                |
// | Scoreboard bench for the stereo PDM CIC decimator                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pdm_stereo_cic;

   localparam int DECIM = 32;
   localparam int OUT_W = 17;
   localparam logic [OUT_W-1:0] C_POS  = 17'h08000;
   localparam logic [OUT_W-1:0] C_NEG  = 17'h18000;
   localparam logic [OUT_W-1:0] C_ZERO = 17'h00000;
   localparam int M_ONES  = 0;
   localparam int M_ZEROS = 1;
   localparam int M_ALT   = 2;

   typedef struct {
      logic [OUT_W-1:0] e0;
      logic [OUT_W-1:0] e1;
      bit               chk;
      int               arr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic std_clk   = 1'b0;
   logic s_n_rst   = 1'b0;
   logic mic_data  = 1'b0;
   logic pcm_ready = 1'b1;
   logic ovr_clr   = 1'b0;
   logic [OUT_W-1:0] pcm_ch0;
   logic [OUT_W-1:0] pcm_ch1;
   logic pcm_valid;
   logic overrun;

   int n_chk       = 0;
   int n_pass      = 0;
   int frames_done = 0;
   int per_cnt     = 0;
   int m0          = M_ONES;
   int m1          = M_ONES;
   logic [OUT_W-1:0] x0 = '0;
   logic [OUT_W-1:0] x1 = '0;
   bit mon_en     = 1'b1;
   bit prev_valid = 1'b0;
   bit prev_xfer  = 1'b0;

   always #5 std_clk = ~std_clk;

   pdm_stereo_cic #(.DECIM(DECIM)) dut (
      .std_clk   (std_clk),
      .s_n_rst   (s_n_rst),
      .mic_data  (mic_data),
      .pcm_ready (pcm_ready),
      .ovr_clr   (ovr_clr),
      .pcm_ch0   (pcm_ch0),
      .pcm_ch1   (pcm_ch1),
      .pcm_valid (pcm_valid),
      .overrun   (overrun)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic pdm_bit(input int m, input int f);
      if (m == M_ONES)  return 1'b1;
      if (m == M_ZEROS) return 1'b0;
      return (f % 2) == 0;
   endfunction

   task automatic set_mode(input int a, input int b, input logic [OUT_W-1:0] p, input logic [OUT_W-1:0] q);
      m0 = a; m1 = b; x0 = p; x1 = q; per_cnt = 0;
   endtask

   // Starts at posedge+1: ch0 driven now, ch1 after the fall, captured at the next rise
   task automatic do_frame();
      exp_t e;
      if (frames_done % DECIM == DECIM - 1) begin
         e.e0  = x0;
         e.e1  = x1;
         e.chk = (per_cnt >= 3);
         e.arr = frames_done + 3;
         sb.push_back(e);
         per_cnt++;
      end
      mic_data = pdm_bit(m0, frames_done);
      @(negedge std_clk);
      #1 mic_data = pdm_bit(m1, frames_done);
      @(posedge std_clk);
      #1 frames_done++;
   endtask

   task automatic run(input int n);
      repeat (n) do_frame();
   endtask

   // A sample is newly presented when valid rises or follows a transfer
   always @(negedge std_clk) begin
      if (s_n_rst) begin
         prev_valid = 1'b0;
         prev_xfer  = 1'b0;
      end else begin
         if (mon_en && pcm_valid && (!prev_valid || prev_xfer)) begin
            if (sb.size() == 0) begin
               check_val("spurious_sample", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("arrival_frame", frames_done, mon_e.arr);
               if (mon_e.chk) begin
                  check_val("pcm_ch0", pcm_ch0, mon_e.e0);
                  check_val("pcm_ch1", pcm_ch1, mon_e.e1);
               end
            end
         end
         prev_valid = pcm_valid;
         prev_xfer  = pcm_valid && pcm_ready;
      end
   end

   initial begin
      #2 s_n_rst = 1'b1;
      repeat (3) @(posedge std_clk);
      #1;
      check_val("rst_valid", pcm_valid, 0);
      check_val("rst_ch0", pcm_ch0, C_ZERO);
      check_val("rst_ch1", pcm_ch1, C_ZERO);
      check_val("rst_overrun", overrun, 0);
      s_n_rst = 1'b0;

      set_mode(M_ONES, M_ONES, C_POS, C_POS);
      run(6 * DECIM);
      set_mode(M_ONES, M_ZEROS, C_POS, C_NEG);
      run(5 * DECIM);
      set_mode(M_ALT, M_ONES, C_ZERO, C_POS);
      run(5 * DECIM);

      // held sample released on the very edge a new one lands
      run(2);
      pcm_ready = 1'b0;
      check_val("t5_valid", pcm_valid, 1);
      run(DECIM - 1);
      check_val("t5_hold_valid", pcm_valid, 1);
      check_val("t5_hold_ch1", pcm_ch1, C_POS);
      pcm_ready = 1'b1;
      run(1);
      check_val("t5_valid_kept", pcm_valid, 1);
      check_val("t5_no_overrun", overrun, 0);
      run(DECIM - 2);

      // backpressure across several strobes
      set_mode(M_ONES, M_ONES, C_POS, C_POS);
      mon_en    = 1'b0;
      pcm_ready = 1'b0;
      run(2);
      check_val("t4_valid", pcm_valid, 1);
      check_val("t4_ch0", pcm_ch0, C_ZERO);
      check_val("t4_ch1", pcm_ch1, C_POS);
      check_val("t4_ovr_first", overrun, 0);
      run(DECIM - 1);
      check_val("t4_ovr_before", overrun, 0);
      run(1);
      check_val("t4_ovr_set", overrun, 1);
      check_val("t4_held_ch0", pcm_ch0, C_ZERO);
      run(65);
      check_val("t4_ovr_sticky", overrun, 1);
      check_val("t4_held_valid", pcm_valid, 1);
      check_val("t4_held_ch0_late", pcm_ch0, C_ZERO);
      pcm_ready = 1'b1;
      run(1);
      check_val("t4_drained", pcm_valid, 0);
      check_val("t4_keep_ch0", pcm_ch0, C_ZERO);
      check_val("t4_ovr_kept", overrun, 1);
      ovr_clr = 1'b1;
      run(1);
      ovr_clr = 1'b0;
      check_val("t4_ovr_clr", overrun, 0);

      // asynchronous reset in the middle of a period
      run((17 - (frames_done % DECIM) + DECIM) % DECIM);
      check_val("t6_ch1_before", pcm_ch1, C_POS);
      #2 s_n_rst = 1'b1;
      #1;
      check_val("t6_rst_valid", pcm_valid, 0);
      check_val("t6_rst_ch0", pcm_ch0, C_ZERO);
      check_val("t6_rst_ch1", pcm_ch1, C_ZERO);
      check_val("t6_rst_overrun", overrun, 0);
      @(posedge std_clk);
      @(posedge std_clk);
      #1 s_n_rst = 1'b0;
      frames_done = 0;
      sb.delete();
      mon_en = 1'b1;
      set_mode(M_ONES, M_ONES, C_POS, C_POS);
      run(6 * DECIM + 3);
      check_val("drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
